// File: rtl/branch_pkg.sv
// Shared branch encodings: B-type funct3 codes and the flag-vector bit layout used by the flagger.
// Purely declarative; no timing or flow-control behaviour of its own.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int FLAG_EQ   = 0;
  localparam int FLAG_NE   = 1;
  localparam int FLAG_LT   = 2;
  localparam int FLAG_GT   = 3;
  localparam int FLAG_LTU  = 4;
  localparam int FLAG_GTU  = 5;
  localparam int NUM_FLAGS = 6;

  typedef logic [NUM_FLAGS-1:0] flag_vec_t;

  // 010 and 011 are the only unassigned B-type encodings.
  function automatic logic f3_illegal(input logic [2:0] funct3);
    return (funct3 == 3'b010) || (funct3 == 3'b011);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode: funct3 against the comparison flag vector.
// Combinational, zero latency; no flow control.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  flag_vec_t  flags,
  output logic       taken,
  output logic       illegal
);

  // Greater-than flags are part of the shared vector but no B-type branch needs them.
  logic unused_gt_flags;
  assign unused_gt_flags = flags[FLAG_GT] ^ flags[FLAG_GTU];

  always_comb begin
    taken   = 1'b0;
    illegal = f3_illegal(funct3);
    case (funct3)
      F3_BEQ:  taken = flags[FLAG_EQ];
      F3_BNE:  taken = flags[FLAG_NE];
      F3_BLT:  taken = flags[FLAG_LT];
      F3_BGE:  taken = ~flags[FLAG_LT];
      F3_BLTU: taken = flags[FLAG_LTU];
      F3_BGEU: taken = ~flags[FLAG_LTU];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves branch flags into taken/target/next-PC/mispredict; 2-stage elastic pipe, 2 edges accept-to-output.
// Valid/ready on both sides, full throughput; flush empties both stages. Stats counters under BRANCH_RESOLVER_STATS_EN.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int WORDSIZE    = 64,
  parameter int INSTR_BYTES = 4,
  parameter int STAT_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_funct3,
  input  logic [WORDSIZE-1:0] in_pc,
  input  logic [WORDSIZE-1:0] in_imm,
  input  logic                in_pred_taken,
  input  logic                flag_equal,
  input  logic                flag_not_equal,
  input  logic                flag_less,
  input  logic                flag_greater,
  input  logic                flag_u_less,
  input  logic                flag_u_greater,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_taken,
  output logic [WORDSIZE-1:0] out_target,
  output logic [WORDSIZE-1:0] out_next_pc,
  output logic                out_mispredict,
  output logic                out_illegal,
  output logic                out_misaligned
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_taken,
  output logic [STAT_WIDTH-1:0] stat_mispredict
`endif
);

  localparam logic [WORDSIZE-1:0] PC_STEP    = WORDSIZE'(INSTR_BYTES);
  localparam logic [WORDSIZE-1:0] ALIGN_MASK = WORDSIZE'(INSTR_BYTES - 1);

  logic                s1_valid;
  logic                s1_taken;
  logic                s1_illegal;
  logic                s1_pred;
  logic [WORDSIZE-1:0] s1_pc;
  logic [WORDSIZE-1:0] s1_target;

  logic      s1_adv, s2_adv, accept;
  logic      c_taken, c_illegal;
  flag_vec_t in_flags;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv & ~flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    in_flags            = '0;
    in_flags[FLAG_EQ]   = flag_equal;
    in_flags[FLAG_NE]   = flag_not_equal;
    in_flags[FLAG_LT]   = flag_less;
    in_flags[FLAG_GT]   = flag_greater;
    in_flags[FLAG_LTU]  = flag_u_less;
    in_flags[FLAG_GTU]  = flag_u_greater;
  end

  branch_cond u_cond (
    .funct3  (in_funct3),
    .flags   (in_flags),
    .taken   (c_taken),
    .illegal (c_illegal)
  );

  // S1: condition and target resolved here; flags are never looked at again.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_taken   <= 1'b0;
      s1_illegal <= 1'b0;
      s1_pred    <= 1'b0;
      s1_pc      <= '0;
      s1_target  <= '0;
    end else begin
      if (flush)       s1_valid <= 1'b0;
      else if (s1_adv) s1_valid <= in_valid;
      if (accept) begin
        s1_taken   <= c_taken;
        s1_illegal <= c_illegal;
        s1_pred    <= in_pred_taken;
        s1_pc      <= in_pc;
        s1_target  <= in_pc + in_imm;
      end
    end
  end

  // S2: out_* are the stage registers, so they hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_target     <= '0;
      out_next_pc    <= '0;
      out_mispredict <= 1'b0;
      out_illegal    <= 1'b0;
      out_misaligned <= 1'b0;
    end else begin
      if (flush)       out_valid <= 1'b0;
      else if (s2_adv) out_valid <= s1_valid;
      if (s1_valid && s2_adv) begin
        out_taken      <= s1_taken;
        out_target     <= s1_target;
        out_next_pc    <= s1_taken ? s1_target : s1_pc + PC_STEP;
        out_mispredict <= (s1_taken != s1_pred) | s1_illegal;
        out_illegal    <= s1_illegal;
        out_misaligned <= s1_taken & ((s1_target & ALIGN_MASK) != '0);
      end
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  // A result leaving during a flush was never delivered, so it is not counted.
  logic out_fire;
  assign out_fire = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches   <= '0;
      stat_taken      <= '0;
      stat_mispredict <= '0;
    end else if (out_fire) begin
      stat_branches <= stat_branches + 1'b1;
      if (out_taken)      stat_taken      <= stat_taken + 1'b1;
      if (out_mispredict) stat_mispredict <= stat_mispredict + 1'b1;
    end
  end
`else
  localparam int unused_stat_width = STAT_WIDTH;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: queue-based reference model checked every cycle, plus literal pins.
module tb_branch_resolver;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [63:0] in_pc, in_imm;
  logic        in_pred_taken;
  logic        flag_equal, flag_not_equal, flag_less, flag_greater, flag_u_less, flag_u_greater;
  logic        flush;
  logic        out_valid, out_ready, out_taken, out_mispredict, out_illegal, out_misaligned;
  logic [63:0] out_target, out_next_pc;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_branches, stat_taken, stat_mispredict;
  logic [31:0] m_br, m_tk, m_mp;
`endif

  branch_resolver #(.WORDSIZE(64), .INSTR_BYTES(4), .STAT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
    .flag_equal(flag_equal), .flag_not_equal(flag_not_equal), .flag_less(flag_less),
    .flag_greater(flag_greater), .flag_u_less(flag_u_less), .flag_u_greater(flag_u_greater),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .out_next_pc(out_next_pc), .out_mispredict(out_mispredict),
    .out_illegal(out_illegal), .out_misaligned(out_misaligned)
`ifdef BRANCH_RESOLVER_STATS_EN
    , .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_mispredict(stat_mispredict)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic [63:0] target;
    logic [63:0] next_pc;
    logic        mis;
    logic        ill;
    logic        misal;
    int          age;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting on DUT at %0t", name, $time);
  endtask

  function automatic exp_t predict(input logic [2:0] f3, input logic [63:0] pc, input logic [63:0] imm,
                                   input logic pred, input logic eq, input logic ne,
                                   input logic lt, input logic ltu);
    exp_t e;
    e.ill = 1'b0;
    case (f3)
      3'd0: e.taken = eq;
      3'd1: e.taken = ne;
      3'd4: e.taken = lt;
      3'd5: e.taken = !lt;
      3'd6: e.taken = ltu;
      3'd7: e.taken = !ltu;
      default: begin e.taken = 1'b0; e.ill = 1'b1; end
    endcase
    e.target  = pc + imm;
    e.next_pc = e.taken ? e.target : pc + 64'd4;
    e.mis     = (e.taken != pred) || e.ill;
    e.misal   = e.taken && ((e.target % 64'd4) != 64'd0);
    e.age     = 1;
    return e;
  endfunction

  // A result is visible once it has seen two edges and everything ahead of it has left.
  function automatic logic m_out_valid();
    return (q.size() > 0) && (q[0].age >= 2);
  endfunction

  // Two stages of storage: room unless both are occupied and the output is stalled.
  function automatic logic m_in_ready();
    return !flush && ((q.size() < 2) || out_ready);
  endfunction

  always @(posedge clk) begin
    logic hs, acc;
    if (reset) begin
      q.delete();
`ifdef BRANCH_RESOLVER_STATS_EN
      m_br = '0; m_tk = '0; m_mp = '0;
`endif
    end else if (flush) begin
      q.delete();
    end else begin
      hs  = m_out_valid() && out_ready;
      acc = in_valid && m_in_ready();
      if (hs) begin
`ifdef BRANCH_RESOLVER_STATS_EN
        m_br = m_br + 1;
        if (q[0].taken) m_tk = m_tk + 1;
        if (q[0].mis)   m_mp = m_mp + 1;
`endif
        void'(q.pop_front());
      end
      foreach (q[i]) q[i].age++;
      if (acc)
        q.push_back(predict(in_funct3, in_pc, in_imm, in_pred_taken,
                            flag_equal, flag_not_equal, flag_less, flag_u_less));
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("in_ready", in_ready, m_in_ready());
      check("out_valid", out_valid, m_out_valid());
      if (m_out_valid()) begin
        check("out_taken", out_taken, q[0].taken);
        check("out_target", out_target, q[0].target);
        check("out_next_pc", out_next_pc, q[0].next_pc);
        check("out_mispredict", out_mispredict, q[0].mis);
        check("out_illegal", out_illegal, q[0].ill);
        check("out_misaligned", out_misaligned, q[0].misal);
      end
`ifdef BRANCH_RESOLVER_STATS_EN
      check("stat_branches", stat_branches, m_br);
      check("stat_taken", stat_taken, m_tk);
      check("stat_mispredict", stat_mispredict, m_mp);
`endif
    end
  end

  task automatic set_req(input logic [2:0] f3, input logic [63:0] pc, input logic [63:0] imm,
                         input logic pred, input logic [5:0] fl);
    in_valid = 1'b1; in_funct3 = f3; in_pc = pc; in_imm = imm; in_pred_taken = pred;
    {flag_u_greater, flag_u_less, flag_greater, flag_less, flag_not_equal, flag_equal} = fl;
  endtask

  // Called and returns at #1 after a rising edge.
  task automatic send(input logic [2:0] f3, input logic [63:0] pc, input logic [63:0] imm,
                      input logic pred, input logic [5:0] fl);
    set_req(f3, pc, imm, pred, fl);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    timeout("send");
    in_valid = 1'b0;
  endtask

  // Returns on the falling edge where out_valid is first seen; lat counts falling edges waited.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = i; return; end
    end
    timeout("wait_out");
  endtask

  initial begin
    int lat, n_seen;
    logic [63:0] seen [3];
    logic will_acc;
    logic [12:0] b13;

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_req(3'd0, '0, '0, 1'b0, 6'd0); in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_taken", out_taken, 1'b0);
    check("rst_out_target", out_target, 64'd0);
    check("rst_out_next_pc", out_next_pc, 64'd0);
    check("rst_out_flags", {out_mispredict, out_illegal, out_misaligned}, 3'b000);
    @(posedge clk); #1;

    // BEQ taken, predicted not-taken
    send(F3_BEQ, 64'h100, 64'h20, 1'b0, 6'b000001);
    wait_out(lat);
    check("beq_latency", lat, 2);
    check("beq_taken", out_taken, 1'b1);
    check("beq_target", out_target, 64'h120);
    check("beq_next_pc", out_next_pc, 64'h120);
    check("beq_mispredict", out_mispredict, 1'b1);
    @(posedge clk); #1;

    // BGEU not taken, both sums wrap
    send(F3_BGEU, 64'hFFFF_FFFF_FFFF_FFFC, 64'd8, 1'b0, 6'b010000);
    wait_out(lat);
    check("bgeu_taken", out_taken, 1'b0);
    check("bgeu_target", out_target, 64'h4);
    check("bgeu_next_pc", out_next_pc, 64'h0);
    check("bgeu_mispredict", out_mispredict, 1'b0);
    @(posedge clk); #1;

    // Illegal funct3
    send(3'b010, 64'h200, 64'h40, 1'b0, 6'b111111);
    wait_out(lat);
    check("ill_illegal", out_illegal, 1'b1);
    check("ill_mispredict", out_mispredict, 1'b1);
    check("ill_taken", out_taken, 1'b0);
    check("ill_next_pc", out_next_pc, 64'h204);
    @(posedge clk); #1;

    // Three requests into a stalled pipe, then release
    out_ready = 1'b0;
    send(F3_BNE, 64'h1000, 64'h10, 1'b1, 6'b000010);
    send(F3_BNE, 64'h2000, 64'h20, 1'b1, 6'b000010);
    set_req(F3_BNE, 64'h3000, 64'h30, 1'b1, 6'b000010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", in_ready, 1'b0);
      check("full_hold_target", out_target, 64'h1010);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    n_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      will_acc = in_valid && in_ready;
      if (out_valid && n_seen < 3) begin
        seen[n_seen] = out_target;
        n_seen++;
      end
      @(posedge clk); #1;
      if (will_acc) in_valid = 1'b0;
    end
    check("drain_count", n_seen, 3);
    check("drain_0", seen[0], 64'h1010);
    check("drain_1", seen[1], 64'h2020);
    check("drain_2", seen[2], 64'h3030);

    // Flush with two in flight and out_ready high
    out_ready = 1'b0;
    send(F3_BLT, 64'h4000, 64'h8, 1'b0, 6'b000100);
    send(F3_BLT, 64'h5000, 64'h8, 1'b0, 6'b000100);
    out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1'b0);
    check("flush_pre_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;

    // Randomized traffic with occasional flush and one mid-stream reset
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      will_acc = in_valid && in_ready;
      @(posedge clk); #1;
      reset     = (c == 700);
      flush     = ($urandom_range(0, 24) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      if (!in_valid || will_acc) begin
        b13 = 13'($urandom);
        set_req(3'($urandom), ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255))
                                                            : {$urandom, $urandom},
                {{51{b13[12]}}, b13}, 1'($urandom), 6'($urandom));
        in_valid = ($urandom_range(0, 3) != 0);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

`ifdef BRANCH_RESOLVER_STATS_EN
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    send(F3_BEQ, 64'h100, 64'h8, 1'b1, 6'b000001); wait_out(lat); @(posedge clk); #1;
    send(F3_BNE, 64'h200, 64'h8, 1'b1, 6'b000010); wait_out(lat); @(posedge clk); #1;
    send(F3_BEQ, 64'h300, 64'h8, 1'b1, 6'b000000); wait_out(lat); @(posedge clk); #1;
    send(F3_BEQ, 64'h400, 64'h8, 1'b0, 6'b000000); wait_out(lat); @(posedge clk); #1;
    out_ready = 1'b0;
    send(F3_BEQ, 64'h500, 64'h8, 1'b0, 6'b000001);
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("stat_br_lit", stat_branches, 32'd4);
    check("stat_tk_lit", stat_taken, 32'd2);
    check("stat_mp_lit", stat_mispredict, 32'd1);
    @(posedge clk); #1;
`endif

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
